linked_list_fifo_mq: RTL and testbench

// Multi-queue FIFO: FIFOS logical queues share one DEPTH-entry data pool through
// per-entry next-pointer links and a hardware free list. Adds per-queue occupancy

---
 rtl/linked_list_fifo_mq.sv | 159 +++++++++++++++
 tb/tb_linked_list_fifo_mq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/linked_list_fifo_mq.sv
// Multi-queue FIFO: FIFOS logical queues share one DEPTH-entry data pool through
// per-entry next-pointer links and a stack-organised free list.
module linked_list_fifo_mq #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 32,
  parameter int FIFOS        = 8,
  parameter int LOG2_DEPTH   = $clog2(DEPTH),
  parameter int LOG2_FIFOS   = $clog2(FIFOS),
  parameter int MAX_PER_FIFO = DEPTH,
  parameter int AF_THRESH    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [LOG2_FIFOS-1:0]            push_fifo,
  input  logic [WIDTH-1:0]                 d,
  output logic                             push_ready,
  input  logic                             pop,
  input  logic [LOG2_FIFOS-1:0]            pop_fifo,
  output logic [WIDTH-1:0]                 q,
  output logic                             q_valid,
  output logic [FIFOS-1:0]                 empty,
  output logic [(LOG2_DEPTH+1)*FIFOS-1:0]  count,
  output logic [LOG2_DEPTH:0]              free_count,
  output logic                             full,
  output logic                             almost_full,
  output logic                             init_done,
  output logic                             err_overflow,
  output logic                             err_underflow
);

  localparam int CW = LOG2_DEPTH + 1;

  typedef enum logic {S_INIT, S_STEADY} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    init_we;
  logic                    init_last;
  logic [LOG2_DEPTH-1:0]   init_cnt;

  logic [WIDTH-1:0]        data_mem [DEPTH];
  logic [LOG2_DEPTH-1:0]   next_mem [DEPTH];
  logic [LOG2_DEPTH-1:0]   head     [FIFOS];
  logic [LOG2_DEPTH-1:0]   tail     [FIFOS];
  logic [CW-1:0]           cnt      [FIFOS];
  logic [CW-1:0]           cnt_nxt  [FIFOS];
  logic [LOG2_DEPTH-1:0]   free_head;
  logic [CW-1:0]           free_cnt;

  logic                    pop_ok;
  logic                    push_ok;
  logic                    same_q;
  logic                    push_empty;
  logic [LOG2_DEPTH-1:0]   pop_entry;
  logic [LOG2_DEPTH-1:0]   alloc_entry;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_cnt == LOG2_DEPTH'(DEPTH - 1)) state_nxt = S_STEADY;
  end

  // FSM: outputs
  always_comb begin
    init_done = (state == S_STEADY);
    init_we   = (state == S_INIT);
    init_last = (state == S_INIT) && (state_nxt == S_STEADY);
  end

  always_ff @(posedge clk) begin
    if (rst)          init_cnt <= '0;
    else if (init_we) init_cnt <= init_cnt + 1'b1;
  end

  // A simultaneous push takes the entry being popped, leaving the free list untouched;
  // this is what lets a push succeed while the pool is exhausted.
  always_comb begin
    pop_entry   = head[pop_fifo];
    pop_ok      = pop & init_done & (cnt[pop_fifo] != '0);
    same_q      = pop_ok & (pop_fifo == push_fifo);
    push_ready  = init_done & ((free_cnt != '0) | pop_ok) &
                  ((cnt[push_fifo] < CW'(MAX_PER_FIFO)) | same_q);
    push_ok     = push & push_ready;
    alloc_entry = pop_ok ? pop_entry : free_head;
    push_empty  = (cnt[push_fifo] == '0) | (same_q & (cnt[push_fifo] == CW'(1)));
  end

  always_comb begin
    for (int i = 0; i < FIFOS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (push_ok && push_fifo == LOG2_FIFOS'(i)) cnt_nxt[i] = cnt_nxt[i] + 1'b1;
      if (pop_ok && pop_fifo == LOG2_FIFOS'(i))   cnt_nxt[i] = cnt_nxt[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q             <= '0;
      q_valid       <= 1'b0;
      free_cnt      <= '0;
      free_head     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      for (int i = 0; i < FIFOS; i++) begin
        cnt[i]  <= '0;
        head[i] <= '0;
        tail[i] <= '0;
      end
    end else begin
      q_valid <= pop_ok;
      if (pop_ok) q <= data_mem[pop_entry];
      if (init_last) begin
        free_cnt  <= CW'(DEPTH);
        free_head <= '0;
      end else if (push_ok && !pop_ok) begin
        free_cnt  <= free_cnt - 1'b1;
        free_head <= next_mem[free_head];
      end else if (pop_ok && !push_ok) begin
        free_cnt  <= free_cnt + 1'b1;
        free_head <= pop_entry;
      end
      if (pop_ok) head[pop_fifo] <= next_mem[pop_entry];
      // Ordered after the pop update so a same-queue refill of a draining queue wins.
      if (push_ok) begin
        tail[push_fifo] <= alloc_entry;
        if (push_empty) head[push_fifo] <= alloc_entry;
      end
      for (int i = 0; i < FIFOS; i++) cnt[i] <= cnt_nxt[i];
      if (push && !push_ready) err_overflow  <= 1'b1;
      if (pop && !pop_ok)      err_underflow <= 1'b1;
    end
  end

  // Pool storage needs no reset: INIT rebuilds every link before any handshake.
  always_ff @(posedge clk) begin
    if (push_ok) data_mem[alloc_entry] <= d;
    if (init_we)                       next_mem[init_cnt] <= init_cnt + 1'b1;
    else if (push_ok && !push_empty)   next_mem[tail[push_fifo]] <= alloc_entry;
    else if (pop_ok && !push_ok)       next_mem[pop_entry] <= free_head;
  end

  always_comb begin
    for (int i = 0; i < FIFOS; i++) begin
      empty[i]            = (cnt[i] == '0);
      count[i*CW +: CW]   = cnt[i];
    end
    free_count  = free_cnt;
    full        = (free_cnt == '0);
    almost_full = (free_cnt <= CW'(AF_THRESH));
  end

endmodule

// File: tb/tb_linked_list_fifo_mq.sv
// Directed bench for linked_list_fifo_mq: one default instance and one with a
// per-queue cap of 4, sharing clock and reset.
module tb_linked_list_fifo_mq;

  logic        clk;
  logic        rst;
  logic        push, pop;
  logic [2:0]  push_fifo, pop_fifo;
  logic [7:0]  d, q;
  logic        push_ready, q_valid, full, almost_full, init_done, err_overflow, err_underflow;
  logic [7:0]  empty;
  logic [47:0] count;
  logic [5:0]  free_count;

  logic        c_push, c_pop;
  logic [2:0]  c_push_fifo, c_pop_fifo;
  logic [7:0]  c_d, c_q;
  logic        c_push_ready, c_q_valid, c_full, c_almost_full, c_init_done, c_err_overflow, c_err_underflow;
  logic [7:0]  c_empty;
  logic [47:0] c_count;
  logic [5:0]  c_free_count;

  int checks   = 0;
  int failures = 0;

  linked_list_fifo_mq u_dut (
    .clk(clk), .rst(rst), .push(push), .push_fifo(push_fifo), .d(d), .push_ready(push_ready),
    .pop(pop), .pop_fifo(pop_fifo), .q(q), .q_valid(q_valid), .empty(empty), .count(count),
    .free_count(free_count), .full(full), .almost_full(almost_full), .init_done(init_done),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  linked_list_fifo_mq #(.MAX_PER_FIFO(4)) u_cap (
    .clk(clk), .rst(rst), .push(c_push), .push_fifo(c_push_fifo), .d(c_d), .push_ready(c_push_ready),
    .pop(c_pop), .pop_fifo(c_pop_fifo), .q(c_q), .q_valid(c_q_valid), .empty(c_empty), .count(c_count),
    .free_count(c_free_count), .full(c_full), .almost_full(c_almost_full), .init_done(c_init_done),
    .err_overflow(c_err_overflow), .err_underflow(c_err_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] cnt_of(input logic [47:0] c, input int i);
    return c[i*6 +: 6];
  endfunction

  task automatic drive(input logic ps, input logic [2:0] pf, input logic [7:0] dd,
                       input logic pp, input logic [2:0] ppf);
    push = ps; push_fifo = pf; d = dd; pop = pp; pop_fifo = ppf;
  endtask

  task automatic cdrive(input logic ps, input logic [2:0] pf, input logic [7:0] dd,
                        input logic pp, input logic [2:0] ppf);
    c_push = ps; c_push_fifo = pf; c_d = dd; c_pop = pp; c_pop_fifo = ppf;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; c_push = 1'b0; c_pop = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_q"}, q, 0);
    chk({tag, "_q_valid"}, q_valid, 0);
    chk({tag, "_empty"}, empty, 8'hFF);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_free_count"}, free_count, 0);
    chk({tag, "_full"}, full, 1);
    chk({tag, "_almost_full"}, almost_full, 1);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_push_ready"}, push_ready, 0);
    chk({tag, "_err_overflow"}, err_overflow, 0);
    chk({tag, "_err_underflow"}, err_underflow, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    cdrive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    push = 1'b1;
    #1;
    check_reset_state("reset");
    push = 1'b0;

    // INIT takes exactly DEPTH cycles after reset release
    rst = 1'b0;
    repeat (31) tick();
    chk("init_not_done_31", init_done, 0);
    drive(1, 0, 8'h00, 0, 0);
    #1;
    chk("init_push_ready_31", push_ready, 0);
    push = 1'b0;
    tick();
    chk("init_done_32", init_done, 1);
    chk("init_free_count", free_count, 32);
    chk("init_empty", empty, 8'hFF);
    chk("init_full", full, 0);
    chk("init_almost_full", almost_full, 0);
    chk("init_err_overflow", err_overflow, 0);
    chk("cap_init_done", c_init_done, 1);
    drive(1, 0, 8'h00, 0, 0);
    #1;
    chk("init_push_ready", push_ready, 1);
    push = 1'b0;

    // interleaved pushes, then in-order pops from q3
    drive(1, 3, 8'h11, 0, 0); tick();
    drive(1, 5, 8'h44, 0, 0); tick();
    drive(1, 3, 8'h22, 0, 0); tick();
    drive(1, 3, 8'h33, 0, 0); tick();
    chk("q3_count", cnt_of(count, 3), 3);
    chk("q5_count", cnt_of(count, 5), 1);
    chk("q35_empty", empty, 8'hD7);
    chk("q35_free_count", free_count, 28);
    drive(0, 0, 0, 1, 3); tick();
    chk("pop1_q", q, 8'h11);
    chk("pop1_q_valid", q_valid, 1);
    drive(0, 0, 0, 1, 3); tick();
    chk("pop2_q", q, 8'h22);
    chk("pop2_q_valid", q_valid, 1);
    drive(0, 0, 0, 1, 3); tick();
    chk("pop3_q", q, 8'h33);
    chk("pop3_q_valid", q_valid, 1);
    tick();
    chk("idle_q_valid", q_valid, 0);
    chk("idle_q_hold", q, 8'h33);
    chk("after_pops_q5_count", cnt_of(count, 5), 1);
    chk("after_pops_q3_count", cnt_of(count, 3), 0);
    chk("after_pops_free_count", free_count, 31);

    drive(0, 0, 0, 1, 5); tick();
    chk("pop_q5_q", q, 8'h44);
    chk("pop_q5_free_count", free_count, 32);

    // fill the whole pool across all queues
    for (int i = 0; i < 32; i++) begin
      drive(1, 3'(i % 8), 8'(8'h80 + i), 0, 0);
      tick();
      chk("fill_free_count", free_count, 64'(31 - i));
      chk("fill_almost_full", almost_full, ((31 - i) <= 2) ? 64'd1 : 64'd0);
    end
    chk("fill_full", full, 1);
    for (int i = 0; i < 8; i++) chk("fill_count", cnt_of(count, i), 4);
    drive(1, 0, 8'hEE, 0, 0);
    #1;
    chk("overflow_push_ready", push_ready, 0);
    tick();
    chk("overflow_err", err_overflow, 1);
    chk("overflow_count0", cnt_of(count, 0), 4);
    chk("overflow_free_count", free_count, 0);

    // pool exhausted: push q0 alongside pop q1 reuses the freed entry
    drive(1, 0, 8'h55, 1, 1);
    #1;
    chk("full_swap_push_ready", push_ready, 1);
    tick();
    chk("full_swap_q", q, 8'h81);
    chk("full_swap_q_valid", q_valid, 1);
    chk("full_swap_free_count", free_count, 0);
    chk("full_swap_count0", cnt_of(count, 0), 5);
    chk("full_swap_count1", cnt_of(count, 1), 3);
    drive(0, 0, 0, 1, 0); tick(); chk("drain0_a", q, 8'h80);
    drive(0, 0, 0, 1, 0); tick(); chk("drain0_b", q, 8'h88);
    drive(0, 0, 0, 1, 0); tick(); chk("drain0_c", q, 8'h90);
    drive(0, 0, 0, 1, 0); tick(); chk("drain0_d", q, 8'h98);
    drive(0, 0, 0, 1, 0); tick(); chk("drain0_e", q, 8'h55);
    chk("drain0_free_count", free_count, 5);
    chk("drain0_empty0", empty[0], 1);

    // underflow: pop empty queue, then push+pop same empty queue
    drive(0, 0, 0, 1, 0); tick();
    chk("underflow_q_valid", q_valid, 0);
    chk("underflow_err", err_underflow, 1);
    chk("underflow_q_hold", q, 8'h55);
    drive(1, 0, 8'h66, 1, 0); tick();
    chk("nobypass_q_valid", q_valid, 0);
    chk("nobypass_count0", cnt_of(count, 0), 1);
    chk("nobypass_free_count", free_count, 4);

    // per-queue cap on the second instance
    for (int i = 0; i < 4; i++) begin
      cdrive(1, 2, 8'(8'hA0 + i), 0, 0);
      #1;
      chk("cap_push_ready", c_push_ready, 1);
      tick();
    end
    chk("cap_count2", cnt_of(c_count, 2), 4);
    cdrive(1, 2, 8'hA4, 0, 0);
    #1;
    chk("cap_fifth_ready", c_push_ready, 0);
    tick();
    chk("cap_fifth_err", c_err_overflow, 1);
    chk("cap_fifth_count2", cnt_of(c_count, 2), 4);
    cdrive(1, 2, 8'hA4, 1, 2);
    #1;
    chk("cap_swap_ready", c_push_ready, 1);
    tick();
    chk("cap_swap_q", c_q, 8'hA0);
    chk("cap_swap_q_valid", c_q_valid, 1);
    chk("cap_swap_count2", cnt_of(c_count, 2), 4);
    for (int i = 1; i < 5; i++) begin
      cdrive(0, 0, 0, 1, 2);
      tick();
      chk("cap_drain_q", c_q, 64'(8'hA0 + i));
    end
    chk("cap_drain_free_count", c_free_count, 32);

    // reset mid-traffic with a pop in flight
    rst = 1'b1;
    drive(1, 7, 8'h99, 1, 7);
    tick();
    #1;
    check_reset_state("midrst");
    rst = 1'b0;
    repeat (32) tick();
    chk("reinit_done", init_done, 1);
    chk("reinit_free_count", free_count, 32);
    chk("reinit_empty", empty, 8'hFF);
    drive(0, 0, 0, 1, 7); tick();
    chk("reinit_old_q_valid", q_valid, 0);
    chk("reinit_old_q", q, 0);
    chk("reinit_err_underflow", err_underflow, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
